// File: rtl/axis_sg_seq_pkg.sv
// Shared types and helpers for the multi-tone waveform sequencer.
// Queue word layout: {phrst_flag, mask[N_TONES-1:0], nsamp[NSAMP_W-1:0]}.
package axis_sg_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2
   } seq_state_e;

   function automatic int mask_lsb(input int nsamp_w);
      return nsamp_w;
   endfunction

   function automatic int flag_bit(input int n_tones, input int nsamp_w);
      return nsamp_w + n_tones;
   endfunction

   function automatic int word_w(input int n_tones, input int nsamp_w);
      return nsamp_w + n_tones + 1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axis_sg_seq_v2_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output and flush.
// Head word is valid on rd_data whenever empty is low.
module sg_seq_fifo
   import axis_sg_seq_pkg::*;
#(
   parameter int DATA_W = 41,
   parameter int DEPTH  = 16
)
(
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    flush,
   input  logic                    wr_en,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    rd_en,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [AW:0]       level_r;
   logic              push_s;
   logic              pop_s;

   assign empty   = (level_r == {(AW+1){1'b0}});
   assign full    = (level_r == LVL_FULL);
   assign push_s  = wr_en & ~full & ~flush;
   assign pop_s   = rd_en & ~empty & ~flush;
   assign rd_data = mem_r[rd_ptr_r];
   assign level   = level_r;

   // storage array; stale contents are never visible because level_r qualifies reads
   always_ff @(posedge aclk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // pointers and occupancy
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {(AW+1){1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LVL_ONE;
            2'b01:   level_r <= level_r - LVL_ONE;
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/axis_sg_seq_v2.sv
// Waveform sequencer: plays queued {flag, mask, nsamp} words into the DDS bank,
// each for exactly nsamp cycles, with gapless back-to-back playback.
module axis_sg_seq_v2
   import axis_sg_seq_pkg::*;
#(
   parameter int N_TONES    = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int NSAMP_W    = 32
)
(
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [NSAMP_W+N_TONES:0]      s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic                          hold_en,
   input  logic                          flush,
   output logic [N_TONES-1:0]            tone_en,
   output logic [N_TONES-1:0]            tone_phrst,
   output logic                          tone_active,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   entry_cnt,
   output logic [15:0]                   underflow_cnt
);
   localparam int WORD_W   = word_w(N_TONES, NSAMP_W);
   localparam int MASK_LSB = mask_lsb(NSAMP_W);
   localparam int FLAG_BIT = flag_bit(N_TONES, NSAMP_W);
   localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [NSAMP_W-1:0] CNT_ONE   = NSAMP_W'(1);
   localparam logic [NSAMP_W-1:0] CNT_ZERO  = {NSAMP_W{1'b0}};
   localparam logic [N_TONES-1:0] MASK_ZERO = {N_TONES{1'b0}};
   localparam logic [LVL_W-1:0]   LVL_ONE   = LVL_W'(1);

   seq_state_e          state_r, state_nx_s;
   logic [NSAMP_W-1:0]  cnt_r, cnt_nx_s;
   logic [N_TONES-1:0]  tone_en_r, tone_en_nx_s;
   logic [N_TONES-1:0]  tone_phrst_r, tone_phrst_nx_s;
   logic                tone_active_r, tone_active_nx_s;
   logic [N_TONES-1:0]  last_mask_r, last_mask_nx_s;
   logic                ready_r;
   logic [15:0]         entry_cnt_r, underflow_cnt_r;

   logic [WORD_W-1:0]   head_s;
   logic [NSAMP_W-1:0]  head_nsamp_s;
   logic [N_TONES-1:0]  head_mask_s;
   logic                head_flag_s;
   logic                fifo_empty_s, fifo_full_s;
   logic [LVL_W-1:0]    level_s;
   logic                push_s, pop_s, play_end_s;

   assign head_nsamp_s  = head_s[NSAMP_W-1:0];
   assign head_mask_s   = head_s[MASK_LSB +: N_TONES];
   assign head_flag_s   = head_s[FLAG_BIT];

   // ready_r only masks the reset period; the flush cycle never accepts a word
   assign s_axis_tready = ready_r & ~fifo_full_s & ~flush;
   assign push_s        = s_axis_tvalid & s_axis_tready;
   assign play_end_s    = (state_r == ST_PLAY) && (cnt_r == CNT_ONE);
   assign pop_s         = ~flush & ~fifo_empty_s & ((state_r == ST_LOAD) | play_end_s);

   sg_seq_fifo #(
      .DATA_W (WORD_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .flush   (flush),
      .wr_en   (push_s),
      .wr_data (s_axis_tdata),
      .rd_en   (pop_s),
      .rd_data (head_s),
      .empty   (fifo_empty_s),
      .full    (fifo_full_s),
      .level   (level_s)
   );

   // next-state and next-output; defaults are the idle outputs
   always_comb begin
      state_nx_s       = state_r;
      cnt_nx_s         = cnt_r;
      tone_en_nx_s     = hold_en ? last_mask_r : MASK_ZERO;
      tone_phrst_nx_s  = MASK_ZERO;
      tone_active_nx_s = 1'b0;
      last_mask_nx_s   = last_mask_r;
      if (flush) begin
         state_nx_s     = ST_IDLE;
         cnt_nx_s       = CNT_ZERO;
         tone_en_nx_s   = MASK_ZERO;
         last_mask_nx_s = MASK_ZERO;
      end else if (pop_s) begin
         cnt_nx_s = head_nsamp_s;
         if (head_nsamp_s != CNT_ZERO) begin
            tone_en_nx_s     = head_mask_s;
            last_mask_nx_s   = head_mask_s;
            tone_active_nx_s = 1'b1;
            tone_phrst_nx_s  = head_flag_s ? head_mask_s : MASK_ZERO;
            state_nx_s       = ST_PLAY;
         end else begin
            // zero-length entry is dropped; keep loading if more words wait behind it
            state_nx_s = (level_s > LVL_ONE) ? ST_LOAD : ST_IDLE;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!fifo_empty_s) state_nx_s = ST_LOAD;
               else               state_nx_s = ST_IDLE;
            end
            ST_PLAY: begin
               if (cnt_r == CNT_ONE) begin
                  state_nx_s = ST_IDLE;
               end else begin
                  cnt_nx_s         = cnt_r - CNT_ONE;
                  tone_en_nx_s     = last_mask_r;
                  tone_active_nx_s = 1'b1;
               end
            end
            default: state_nx_s = ST_IDLE;
         endcase
      end
   end

   // sequencing and output registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ready_r       <= 1'b0;
         state_r       <= ST_IDLE;
         cnt_r         <= CNT_ZERO;
         tone_en_r     <= MASK_ZERO;
         tone_phrst_r  <= MASK_ZERO;
         tone_active_r <= 1'b0;
         last_mask_r   <= MASK_ZERO;
      end else begin
         ready_r       <= 1'b1;
         state_r       <= state_nx_s;
         cnt_r         <= cnt_nx_s;
         tone_en_r     <= tone_en_nx_s;
         tone_phrst_r  <= tone_phrst_nx_s;
         tone_active_r <= tone_active_nx_s;
         last_mask_r   <= last_mask_nx_s;
      end
   end

   // status counters survive flush; underflow means the queue ran dry at entry end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         entry_cnt_r     <= 16'h0000;
         underflow_cnt_r <= 16'h0000;
      end else if (!flush && play_end_s) begin
         entry_cnt_r <= sat_inc16(entry_cnt_r);
         if (fifo_empty_s) underflow_cnt_r <= sat_inc16(underflow_cnt_r);
      end
   end

   assign tone_en       = tone_en_r;
   assign tone_phrst    = tone_phrst_r;
   assign tone_active   = tone_active_r;
   assign fifo_level    = level_s;
   assign entry_cnt     = entry_cnt_r;
   assign underflow_cnt = underflow_cnt_r;

endmodule

// File: tb/tb_axis_sg_seq_v2.sv
// Directed bench for axis_sg_seq_v2: table of single-entry plays plus
// hand-written multi-entry, backpressure, flush and reset sequences.
module tb_axis_sg_seq_v2;
   localparam int NT = 8;
   localparam int FD = 16;
   localparam int NW = 32;

   logic            aclk = 1'b0;
   logic            aresetn = 1'b0;
   logic [NW+NT:0]  s_axis_tdata = '0;
   logic            s_axis_tvalid = 1'b0;
   logic            s_axis_tready;
   logic            hold_en = 1'b0;
   logic            flush = 1'b0;
   logic [NT-1:0]   tone_en;
   logic [NT-1:0]   tone_phrst;
   logic            tone_active;
   logic [4:0]      fifo_level;
   logic [15:0]     entry_cnt;
   logic [15:0]     underflow_cnt;

   axis_sg_seq_v2 #(.N_TONES(NT), .FIFO_DEPTH(FD), .NSAMP_W(NW)) dut (
      .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .hold_en(hold_en), .flush(flush), .tone_en(tone_en), .tone_phrst(tone_phrst),
      .tone_active(tone_active), .fifo_level(fifo_level), .entry_cnt(entry_cnt),
      .underflow_cnt(underflow_cnt)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic       flag;
      logic [7:0] mask;
      int         ns;
      logic       hold;
      logic [7:0] exp_before;
      logic [7:0] exp_ph;
      int         exp_len;
      logic [7:0] exp_after;
      int         d_entry;
      int         d_under;
   } vec_t;

   vec_t          tbl[6];
   int            n_vec = 0;
   int            n_bad = 0;
   logic [NT-1:0] en_q[$];
   logic [NT-1:0] ph_q[$];
   logic          act_q[$];
   logic [15:0]   exp_entry = 16'd0;
   logic [15:0]   exp_under = 16'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic push(input logic flag, input logic [NT-1:0] mask, input logic [NW-1:0] ns);
      logic acc;
      int   guard;
      guard = 0;
      s_axis_tdata  = {flag, mask, ns};
      s_axis_tvalid = 1'b1;
      do begin
         acc = s_axis_tready;
         tick();
         guard++;
      end while (!acc && guard < 30000);
      s_axis_tvalid = 1'b0;
      chk("push_accept", acc, 1'b1);
   endtask

   task automatic capture(input int n);
      en_q.delete();
      ph_q.delete();
      act_q.delete();
      for (int i = 0; i < n; i++) begin
         tick();
         en_q.push_back(tone_en);
         ph_q.push_back(tone_phrst);
         act_q.push_back(tone_active);
      end
   endtask

   function automatic int first_active();
      for (int i = 0; i < act_q.size(); i++) if (act_q[i]) return i;
      return -1;
   endfunction

   task automatic check_run(input string name, input int start, input int len,
                            input logic [NT-1:0] mask, input logic [NT-1:0] ph0);
      int bad;
      bad = 0;
      for (int j = 0; j < len; j++) begin
         if (start + j >= en_q.size()) bad++;
         else if (en_q[start+j] !== mask || act_q[start+j] !== 1'b1 ||
                  ph_q[start+j] !== ((j == 0) ? ph0 : 8'h00)) bad++;
      end
      chk({name, "_badcycles"}, bad, 0);
   endtask

   task automatic check_idle(input string name, input int idx, input logic [NT-1:0] exp_en);
      if (idx >= en_q.size()) chk({name, "_range"}, idx, en_q.size() - 1);
      else chk(name, {act_q[idx], ph_q[idx], en_q[idx]}, {1'b0, 8'h00, exp_en});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   f, nph, n_acc, acc_at_full, lvl_at_full, low_run;
      logic acc, low_done;
      logic [15:0] e_sv, u_sv;

      tbl[0] = '{1'b1, 8'h05,  1, 1'b0, 8'h00, 8'h05,  1, 8'h00, 1, 1};
      tbl[1] = '{1'b0, 8'h3C, 10, 1'b1, 8'h05, 8'h00, 10, 8'h3C, 1, 1};
      tbl[2] = '{1'b0, 8'h3C, 10, 1'b0, 8'h00, 8'h00, 10, 8'h00, 1, 1};
      tbl[3] = '{1'b1, 8'hFF,  3, 1'b1, 8'h3C, 8'hFF,  3, 8'hFF, 1, 1};
      tbl[4] = '{1'b0, 8'h33,  0, 1'b1, 8'hFF, 8'h00,  0, 8'hFF, 0, 0};
      tbl[5] = '{1'b1, 8'h80,  2, 1'b0, 8'h00, 8'h80,  2, 8'h00, 1, 1};

      // reset state
      repeat (3) @(posedge aclk);
      #1;
      chk("reset_tready", s_axis_tready, 1'b0);
      chk("reset_outs", {tone_en, tone_phrst, tone_active, fifo_level, entry_cnt, underflow_cnt}, 54'd0);
      aresetn = 1'b1;
      tick();
      chk("release_tready", s_axis_tready, 1'b1);

      // single-entry table: latency 2, exact duration, phase strobe, idle/hold value
      for (int v = 0; v < 6; v++) begin
         hold_en = tbl[v].hold;
         fork
            push(tbl[v].flag, tbl[v].mask, tbl[v].ns);
            capture(tbl[v].ns + 8);
         join
         check_idle($sformatf("v%0d_before", v), 0, tbl[v].exp_before);
         if (tbl[v].exp_len > 0) begin
            chk($sformatf("v%0d_latency", v), first_active(), 2);
            check_run($sformatf("v%0d_play", v), 2, tbl[v].exp_len, tbl[v].mask, tbl[v].exp_ph);
         end else begin
            chk($sformatf("v%0d_noplay", v), first_active(), -1);
         end
         check_idle($sformatf("v%0d_after", v), 2 + tbl[v].exp_len, tbl[v].exp_after);
         exp_entry += 16'(tbl[v].d_entry);
         exp_under += 16'(tbl[v].d_under);
         chk($sformatf("v%0d_entry_cnt", v), entry_cnt, exp_entry);
         chk($sformatf("v%0d_underflow_cnt", v), underflow_cnt, exp_under);
      end

      // three long entries back to back, no gap
      hold_en = 1'b0;
      fork
         begin
            push(1'b0, 8'h81, 2500);
            push(1'b0, 8'h03, 2500);
            push(1'b0, 8'h05, 2500);
         end
         capture(7510);
      join
      chk("s1_latency", first_active(), 2);
      check_run("s1_e0", 2, 2500, 8'h81, 8'h00);
      check_run("s1_e1", 2502, 2500, 8'h03, 8'h00);
      check_run("s1_e2", 5002, 2500, 8'h05, 8'h00);
      check_idle("s1_end", 7502, 8'h00);
      exp_entry += 16'd3;
      exp_under += 16'd1;
      chk("s1_entry_cnt", entry_cnt, exp_entry);
      chk("s1_underflow_cnt", underflow_cnt, exp_under);

      // phase restart on each of two identical entries
      fork
         begin
            push(1'b1, 8'h05, 100);
            push(1'b1, 8'h05, 100);
         end
         capture(210);
      join
      check_run("s2_e0", 2, 100, 8'h05, 8'h05);
      check_run("s2_e1", 102, 100, 8'h05, 8'h05);
      check_idle("s2_end", 202, 8'h00);
      nph = 0;
      foreach (ph_q[i]) if (ph_q[i] != 8'h00) nph++;
      chk("s2_phrst_count", nph, 2);
      exp_entry += 16'd2;
      exp_under += 16'd1;
      chk("s2_entry_cnt", entry_cnt, exp_entry);

      // 20 words against a 16-deep queue: backpressure and ordering
      n_acc = 0; acc_at_full = -1; lvl_at_full = -1; low_run = 0; low_done = 1'b0;
      fork
         begin
            s_axis_tvalid = 1'b1;
            for (int g = 0; g < 30000 && n_acc < 20; g++) begin
               s_axis_tdata = {1'b0, 8'(n_acc + 1), 32'd1000};
               acc = s_axis_tready;
               if (!acc && acc_at_full < 0) begin
                  acc_at_full = n_acc;
                  lvl_at_full = int'(fifo_level);
               end
               if (!acc && !low_done) low_run++;
               else if (acc && low_run > 0) low_done = 1'b1;
               tick();
               if (acc) n_acc++;
            end
            s_axis_tvalid = 1'b0;
         end
         capture(20012);
      join
      chk("s3_accepted_at_full", acc_at_full, 17);
      chk("s3_level_at_full", lvl_at_full, 16);
      chk("s3_first_stall_len", low_run, 986);
      chk("s3_total_accepted", n_acc, 20);
      chk("s3_latency", first_active(), 2);
      for (int i = 0; i < 20; i++)
         check_run($sformatf("s3_e%0d", i), 2 + 1000 * i, 1000, 8'(i + 1), 8'h00);
      check_idle("s3_end", 20002, 8'h00);
      exp_entry += 16'd20;
      exp_under += 16'd1;
      chk("s3_entry_cnt", entry_cnt, exp_entry);
      chk("s3_underflow_cnt", underflow_cnt, exp_under);

      // zero-length entry in the middle costs exactly one idle cycle
      fork
         begin
            push(1'b0, 8'h0F, 50);
            push(1'b0, 8'h33, 0);
            push(1'b0, 8'hF0, 50);
         end
         capture(110);
      join
      check_run("s4_a", 2, 50, 8'h0F, 8'h00);
      check_idle("s4_gap", 52, 8'h00);
      check_run("s4_b", 53, 50, 8'hF0, 8'h00);
      check_idle("s4_end", 103, 8'h00);
      exp_entry += 16'd2;
      exp_under += 16'd1;
      chk("s4_entry_cnt", entry_cnt, exp_entry);
      chk("s4_underflow_cnt", underflow_cnt, exp_under);

      // flush during the first of five queued entries
      for (int i = 0; i < 5; i++) push(1'b0, 8'(8'h11 * (i + 1)), 100);
      repeat (17) tick();
      chk("f_pre_active", tone_active, 1'b1);
      e_sv = entry_cnt;
      u_sv = underflow_cnt;
      flush = 1'b1;
      s_axis_tdata  = {1'b0, 8'hAA, 32'd5};
      s_axis_tvalid = 1'b1;
      #1;
      chk("f_tready", s_axis_tready, 1'b0);
      tick();
      chk("f_outs", {tone_en, tone_phrst, tone_active, fifo_level}, 22'd0);
      chk("f_counters", {entry_cnt, underflow_cnt}, {e_sv, u_sv});
      flush = 1'b0;
      s_axis_tvalid = 1'b0;
      repeat (3) tick();
      chk("f_post", {tone_active, fifo_level}, 6'd0);

      // async reset while playing
      push(1'b0, 8'h42, 100);
      push(1'b0, 8'h24, 100);
      repeat (10) tick();
      chk("r_pre_active", tone_active, 1'b1);
      aresetn = 1'b0;
      #1;
      chk("r_outs", {tone_en, tone_phrst, tone_active, fifo_level, entry_cnt, underflow_cnt}, 54'd0);
      chk("r_tready", s_axis_tready, 1'b0);
      tick();
      aresetn = 1'b1;
      repeat (4) tick();
      chk("r_after", {tone_active, fifo_level, entry_cnt, underflow_cnt}, 38'd0);
      chk("r_after_tready", s_axis_tready, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
